// File: rtl/level_kary_pkg.sv
// Shared heap types for the pipelined-heap level storage.
// entry_t is the stored heap entry. log2 gives the bit count needed to
// index a power-of-two quantity.
package pheapTypes;

  typedef logic [7:0] entry_t;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/level_kary_bank.sv
// level_bank: one bank of a heap level, a DEPTH-deep synchronous RAM with
// one write port and one registered read port.
// Ports:
//   clk            - clock
//   we/waddr/wdata - write port, commits at the rising edge
//   re/raddr       - read port, data appears on rdata one cycle later
//   rdata          - read data; a same-cycle write to raddr is not visible
//                    (old contents are returned)
// Contents are not reset; the owner clears them.
module level_bank #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/level_kary.sv
// level_kary: storage for one level of a k-ary pipelined heap.
// Entry i lives in bank (i mod ARITY), row (i >> LA), so the ARITY children
// of parent p are row p of every bank and are fetched in one access.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   init_done         - high once the zero-clear sweep has finished
//   top_*             - single-entry read/write port (read has priority)
//   bot_req/bot_paddr - child-group read for parent p from the level below
//   bot_ready/rvalid  - handshake for the child-group read
//   bot_rdata         - child k in slice [k*ENTRY_W +: ENTRY_W]
//
// state  | meaning
// INIT   | clearing row row_cnt of every bank, requests ignored
// READY  | serving top and bottom requests
module level_kary
  import pheapTypes::*;
#(
  parameter int LEVEL   = 2,
  parameter int ARITY   = 2,
  parameter int ENTRY_W = $bits(entry_t)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_done,
  input  logic                       top_req,
  input  logic                       top_we,
  input  logic [(LEVEL-1)*log2(ARITY)-1:0] top_addr,
  input  logic [ENTRY_W-1:0]         top_wdata,
  output logic                       top_ready,
  output logic                       top_rvalid,
  output logic [ENTRY_W-1:0]         top_rdata,
  input  logic                       bot_req,
  input  logic [(((LEVEL-2)*log2(ARITY)) > 1 ? ((LEVEL-2)*log2(ARITY)) : 1)-1:0] bot_paddr,
  output logic                       bot_ready,
  output logic                       bot_rvalid,
  output logic [ARITY*ENTRY_W-1:0]   bot_rdata
);

  localparam int LA      = log2(ARITY);
  localparam int ADDR_W  = (LEVEL-1)*LA;
  localparam int ROWS    = ARITY**(LEVEL-2);
  localparam int PADDR_W = ((LEVEL-2)*LA > 1) ? (LEVEL-2)*LA : 1;

  if (LEVEL < 2 || ARITY < 2 || (ARITY & (ARITY-1)) != 0) begin : g_bad_params
    $error("level_kary: LEVEL must be >= 2 and ARITY a power of two >= 2");
  end

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]         state;
  logic [PADDR_W-1:0] row_cnt;

  logic               top_acc, top_rd, top_wr, bot_acc;
  logic [LA-1:0]      top_bank;
  logic [PADDR_W-1:0] top_row, bot_row, rd_row;
  logic [ENTRY_W-1:0] bank_rd [ARITY];
  logic [ARITY-1:0]   fwd_hit_d, fwd_hit_q;
  logic [ENTRY_W-1:0] fwd_data_q;
  logic [LA-1:0]      top_sel_q;
  logic               top_rvalid_q, bot_rvalid_q;

  assign init_done = (state == ST_READY);
  assign top_ready = init_done;
  assign bot_ready = init_done & ~(top_req & ~top_we);

  assign top_acc  = top_req & init_done;
  assign top_rd   = top_acc & ~top_we;
  assign top_wr   = top_acc & top_we;
  assign bot_acc  = bot_req & bot_ready;

  assign top_bank = top_addr[LA-1:0];
  assign top_row  = PADDR_W'(top_addr >> LA);
  // A two-level heap has a single row, so the parent index is meaningless.
  assign bot_row  = bot_paddr & {PADDR_W{(LEVEL > 2)}};
  // Only one read can be accepted per cycle; a top read blocks the bottom.
  assign rd_row   = top_rd ? top_row : bot_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      row_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (row_cnt == PADDR_W'(ROWS-1)) state <= ST_READY;
      else row_cnt <= row_cnt + PADDR_W'(1);
    end
  end

  for (genvar k = 0; k < ARITY; k++) begin : g_bank
    logic               we_k;
    logic [PADDR_W-1:0] waddr_k;
    logic [ENTRY_W-1:0] wdata_k;

    assign we_k    = ~init_done | (top_wr & (top_bank == LA'(k)));
    assign waddr_k = init_done ? top_row : row_cnt;
    assign wdata_k = init_done ? top_wdata : '0;

    // The bank returns pre-write data, so a write landing on a child being
    // read in the same cycle is forwarded around the RAM.
    assign fwd_hit_d[k] = bot_acc & top_wr & (top_row == bot_row) &
                          (top_bank == LA'(k));

    level_bank #(
      .DEPTH(ROWS),
      .WIDTH(ENTRY_W),
      .AW   (PADDR_W)
    ) u_bank (
      .clk  (clk),
      .we   (we_k),
      .waddr(waddr_k),
      .wdata(wdata_k),
      .re   (top_rd | bot_acc),
      .raddr(rd_row),
      .rdata(bank_rd[k])
    );

    assign bot_rdata[k*ENTRY_W +: ENTRY_W] =
      bot_rvalid_q ? (fwd_hit_q[k] ? fwd_data_q : bank_rd[k]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_rvalid_q <= 1'b0;
      bot_rvalid_q <= 1'b0;
      top_sel_q    <= '0;
      fwd_hit_q    <= '0;
      fwd_data_q   <= '0;
    end else begin
      top_rvalid_q <= top_rd;
      bot_rvalid_q <= bot_acc;
      top_sel_q    <= top_bank;
      fwd_hit_q    <= fwd_hit_d;
      fwd_data_q   <= top_wdata;
    end
  end

  assign top_rvalid = top_rvalid_q;
  assign bot_rvalid = bot_rvalid_q;
  assign top_rdata  = top_rvalid_q ? bank_rd[top_sel_q] : '0;

endmodule

// File: tb/tb_level_kary.sv
module tb_level_kary;

  localparam int ROWS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done;
  logic        top_req = 1'b0, top_we = 1'b0;
  logic [3:0]  top_addr = '0;
  logic [7:0]  top_wdata = '0;
  logic        top_ready, top_rvalid;
  logic [7:0]  top_rdata;
  logic        bot_req = 1'b0;
  logic [1:0]  bot_paddr = '0;
  logic        bot_ready, bot_rvalid;
  logic [31:0] bot_rdata;

  level_kary #(.LEVEL(3), .ARITY(4), .ENTRY_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .top_req(top_req), .top_we(top_we), .top_addr(top_addr),
    .top_wdata(top_wdata), .top_ready(top_ready), .top_rvalid(top_rvalid),
    .top_rdata(top_rdata), .bot_req(bot_req), .bot_paddr(bot_paddr),
    .bot_ready(bot_ready), .bot_rvalid(bot_rvalid), .bot_rdata(bot_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [16];
  logic [7:0]  q_top [$];
  logic [31:0] q_bot [$];
  int          edges = 0;

  // Edges seen since reset release; the clear sweep takes ROWS of them.
  always @(posedge clk) begin
    if (!rst_n) edges = 0;
    else edges = edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (top_rvalid === 1'b1) begin
        if (q_top.size() == 0) chk("top_rvalid_unexpected", 1, 0);
        else chk("top_rdata", {24'h0, top_rdata}, {24'h0, q_top.pop_front()});
      end else begin
        chk("top_rdata_idle", {24'h0, top_rdata}, 0);
      end
      if (bot_rvalid === 1'b1) begin
        if (q_bot.size() == 0) chk("bot_rvalid_unexpected", 1, 0);
        else chk("bot_rdata", bot_rdata, q_bot.pop_front());
      end else begin
        chk("bot_rdata_idle", bot_rdata, 0);
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance and queues responses.
  task automatic op(input bit treq, input bit twe, input logic [3:0] taddr,
                    input logic [7:0] twd, input bit breq, input logic [1:0] bp);
    bit m_init, exp_br;
    logic [31:0] grp;
    @(negedge clk);
    top_req = treq; top_we = twe; top_addr = taddr; top_wdata = twd;
    bot_req = breq; bot_paddr = bp;
    #1;
    m_init = (edges >= ROWS);
    exp_br = m_init && !(treq && !twe);
    chk("init_done", {31'h0, init_done}, {31'h0, m_init});
    chk("top_ready", {31'h0, top_ready}, {31'h0, m_init});
    chk("bot_ready", {31'h0, bot_ready}, {31'h0, exp_br});
    if (m_init && treq && !twe) q_top.push_back(mem[taddr]);
    if (exp_br && breq) begin
      for (int k = 0; k < 4; k++) begin
        if (m_init && treq && twe && (int'(taddr) == int'(bp) * 4 + k))
          grp[k*8 +: 8] = twd;
        else
          grp[k*8 +: 8] = mem[int'(bp) * 4 + k];
      end
      q_bot.push_back(grp);
    end
    if (m_init && treq && twe) mem[taddr] = twd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 4'h0, 8'h00, 0, 2'd0);
  endtask

  task automatic check_reset_outputs();
    top_req = 1'b1; top_we = 1'b0; bot_req = 1'b1;
    #1;
    chk("rst_init_done",  {31'h0, init_done},  0);
    chk("rst_top_ready",  {31'h0, top_ready},  0);
    top_we = 1'b1;
    #1;
    chk("rst_bot_ready",  {31'h0, bot_ready},  0);
    chk("rst_top_rvalid", {31'h0, top_rvalid}, 0);
    chk("rst_bot_rvalid", {31'h0, bot_rvalid}, 0);
    chk("rst_top_rdata",  {24'h0, top_rdata},  0);
    chk("rst_bot_rdata",  bot_rdata,           0);
    top_req = 1'b0; top_we = 1'b0; bot_req = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    release_reset();

    // Requests during the clear sweep must be ignored.
    for (int i = 0; i < ROWS; i++)
      op(1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1, 2'($urandom));

    // Cleared contents, streamed back to back.
    for (int p = 0; p < 4; p++) op(0, 0, 4'h0, 8'h00, 1, 2'(p));

    op(1, 1, 4'd9,  8'hA5, 0, 2'd0);
    op(1, 1, 4'd10, 8'h3C, 0, 2'd0);
    op(0, 0, 4'h0,  8'h00, 1, 2'd2);

    // Same-cycle write to a child of the group being read.
    op(1, 1, 4'd13, 8'h77, 1, 2'd3);

    // Top read blocks the bottom; the bottom retries next cycle.
    op(1, 0, 4'd9, 8'h00, 1, 2'd2);
    op(0, 0, 4'h0, 8'h00, 1, 2'd2);

    // Read immediately after a write to the same entry.
    op(1, 1, 4'd5, 8'h11, 0, 2'd0);
    op(1, 0, 4'd5, 8'h00, 0, 2'd0);
    op(1, 1, 4'd6, 8'h22, 0, 2'd0);
    op(0, 0, 4'h0, 8'h00, 1, 2'd1);
    idle(2);

    for (int i = 0; i < 400; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
         8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom));
    idle(2);

    // Reset lands right after a read was accepted: its response is lost.
    op(1, 0, 4'd9, 8'h00, 1, 2'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_top.delete();
    q_bot.delete();
    check_reset_outputs();
    repeat (2) @(posedge clk);
    release_reset();
    idle(ROWS);
    for (int p = 0; p < 4; p++) op(0, 0, 4'h0, 8'h00, 1, 2'(p));
    for (int i = 0; i < 16; i++) op(1, 0, 4'(i), 8'h00, 0, 2'd0);
    idle(3);

    chk("top_pending_left", q_top.size(), 0);
    chk("bot_pending_left", q_bot.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
